// File: rtl/fft64_out_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft64_out_stream_pkg : shared FFT frame sizes, drop-counter width   |
// | and read-side state encoding.                    Revision: 1.0      |
// +--------------------------------------------------------------------+
package fft64_out_stream_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_POINTS   = 64;
  localparam int LOGN       = $clog2(N_POINTS);
  localparam int DROP_CNT_W = 8;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/fft64_out_stream_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_frame_buf : one complex frame, whole-frame parallel capture,    |
// | single indexed combinational read port.          Revision: 1.0      |
// +--------------------------------------------------------------------+
module fft_frame_buf #(
  parameter int DATA_WIDTH = fft64_out_stream_pkg::DATA_WIDTH,
  parameter int N_POINTS   = fft64_out_stream_pkg::N_POINTS
) (
  input  logic                                 clk,
  input  logic                                 we_i,
  input  logic [N_POINTS-1:0][DATA_WIDTH-1:0]  wr_real_i,
  input  logic [N_POINTS-1:0][DATA_WIDTH-1:0]  wr_imag_i,
  input  logic [$clog2(N_POINTS)-1:0]          rd_idx_i,
  output logic [DATA_WIDTH-1:0]                rd_real_o,
  output logic [DATA_WIDTH-1:0]                rd_imag_o
);
  import fft64_out_stream_pkg::*;

  logic [N_POINTS-1:0][DATA_WIDTH-1:0] mem_real_q;
  logic [N_POINTS-1:0][DATA_WIDTH-1:0] mem_imag_q;

  // Contents are deliberately not reset; validity lives in the owner's full flag.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_real_q <= wr_real_i;
      mem_imag_q <= wr_imag_i;
    end
  end

  assign rd_real_o = mem_real_q[rd_idx_i];
  assign rd_imag_o = mem_imag_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/fft64_out_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft64_out_stream : ping-pong buffers a parallel FFT frame and        |
// | streams it out one bin per beat over valid/ready. Revision: 1.0     |
// +--------------------------------------------------------------------+
module fft64_out_stream #(
  parameter int DATA_WIDTH = fft64_out_stream_pkg::DATA_WIDTH,
  parameter int N_POINTS   = fft64_out_stream_pkg::N_POINTS
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          done_in,
  input  logic [N_POINTS-1:0][DATA_WIDTH-1:0]           din_real,
  input  logic [N_POINTS-1:0][DATA_WIDTH-1:0]           din_imag,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [DATA_WIDTH-1:0]                         m_real,
  output logic [DATA_WIDTH-1:0]                         m_imag,
  output logic [$clog2(N_POINTS)-1:0]                   m_index,
  output logic                                          m_last,
  output logic                                          overflow,
  output logic [fft64_out_stream_pkg::DROP_CNT_W-1:0]   drop_cnt,
  output logic                                          busy
);
  import fft64_out_stream_pkg::*;

  localparam int               IDX_W    = $clog2(N_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  rd_state_e              state_q, state_d;
  logic [1:0]             full_q, full_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_last_q, m_last_d;
  logic [IDX_W-1:0]       m_index_q, m_index_d;
  logic [DATA_WIDTH-1:0]  m_real_q, m_real_d;
  logic [DATA_WIDTH-1:0]  m_imag_q, m_imag_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic                   hs, last_hs, wr_free, capture, drop;
  logic                   rd_buf, load;
  logic [IDX_W-1:0]       rd_idx;
  logic [1:0]             buf_we;
  logic [DATA_WIDTH-1:0]  buf_real [2];
  logic [DATA_WIDTH-1:0]  buf_imag [2];

  assign hs      = m_valid_q & m_ready;
  assign last_hs = hs & m_last_q;
  // A buffer draining its final beat this cycle may be refilled at the same edge.
  assign wr_free = ~full_q[wr_sel_q] | (last_hs & (rd_sel_q == wr_sel_q));
  assign capture = done_in & ~rst & wr_free;
  assign drop    = done_in & ~rst & ~wr_free;
  assign buf_we  = {capture & wr_sel_q, capture & ~wr_sel_q};

  for (genvar g = 0; g < 2; g++) begin : g_buf
    fft_frame_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_POINTS   (N_POINTS)
    ) u_buf (
      .clk       (clk),
      .we_i      (buf_we[g]),
      .wr_real_i (din_real),
      .wr_imag_i (din_imag),
      .rd_idx_i  (rd_idx),
      .rd_real_o (buf_real[g]),
      .rd_imag_o (buf_imag[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_index_d  = m_index_q;
    m_real_d   = m_real_q;
    m_imag_d   = m_imag_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    rd_buf     = rd_sel_q;
    rd_idx     = m_index_q;
    load       = 1'b0;

    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_sel_q]) begin
          load    = 1'b1;
          rd_idx  = '0;
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (hs) begin
          if (m_last_q) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            rd_buf           = ~rd_sel_q;
            rd_idx           = '0;
            // Chain straight into the other buffer so frames stay bubble-free.
            if (full_q[~rd_sel_q]) begin
              load = 1'b1;
            end else begin
              state_d   = RD_IDLE;
              m_valid_d = 1'b0;
              m_last_d  = 1'b0;
              m_index_d = '0;
            end
          end else begin
            load   = 1'b1;
            rd_idx = m_index_q + 1'b1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    if (load) begin
      m_valid_d = 1'b1;
      m_index_d = rd_idx;
      m_last_d  = (rd_idx == LAST_IDX);
      m_real_d  = buf_real[rd_buf];
      m_imag_d  = buf_imag[rd_buf];
    end

    // Capture after release so a same-cycle refill leaves the flag set.
    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_index_q  <= '0;
      m_real_q   <= '0;
      m_imag_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_index_q  <= m_index_d;
      m_real_q   <= m_real_d;
      m_imag_q   <= m_imag_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_index  = m_index_q;
  assign m_real   = m_real_q;
  assign m_imag   = m_imag_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = |full_q;

endmodule
`default_nettype wire

// File: tb/tb_fft64_out_stream.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_fft64_out_stream : directed bench for the FFT frame streamer.    |
// |                                                  Revision: 1.0      |
// +--------------------------------------------------------------------+
module tb_fft64_out_stream;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 done_in;
  logic [63:0][15:0]    din_real;
  logic [63:0][15:0]    din_imag;
  logic                 m_valid;
  logic                 m_ready;
  logic [15:0]          m_real;
  logic [15:0]          m_imag;
  logic [5:0]           m_index;
  logic                 m_last;
  logic                 overflow;
  logic [7:0]           drop_cnt;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  fft64_out_stream dut (
    .clk      (clk),
    .rst      (rst),
    .done_in  (done_in),
    .din_real (din_real),
    .din_imag (din_imag),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_real   (m_real),
    .m_imag   (m_imag),
    .m_index  (m_index),
    .m_last   (m_last),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Frame tag t, bin k carries real = 100*t + k and imag = its negation.
  function automatic logic [15:0] exp_re(input int tag, input int k);
    return 16'(tag * 100 + k);
  endfunction

  function automatic logic [15:0] exp_im(input int tag, input int k);
    return 16'(-(tag * 100 + k));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int tag);
    for (int k = 0; k < 64; k++) begin
      din_real[k] = exp_re(tag, k);
      din_imag[k] = exp_im(tag, k);
    end
  endtask

  task automatic pulse(input int tag);
    fill(tag);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
  endtask

  // Receive nbeats beats of frame `tag`. bp selects the 1,0,0,1 ready pattern.
  // contig: 0 none, 1 no gaps after first beat, 2 no gaps at all.
  // inj_at >= 0 raises done_in with frame inj_tag on that loop cycle.
  task automatic recv_frame(input int tag, input int nbeats, input bit bp,
                            input int contig, input int inj_at, input int inj_tag);
    int          k     = 0;
    int          guard = 0;
    int          phase = 0;
    bit          held;
    logic [39:0] snap;
    while (k < nbeats && guard < 400) begin
      m_ready = bp ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b1;
      phase++;
      if (guard == inj_at) begin
        fill(inj_tag);
        done_in = 1'b1;
      end else begin
        done_in = 1'b0;
      end
      held = 1'b0;
      if (m_valid && m_ready) begin
        check($sformatf("t%0d_idx%0d", tag, k), 64'(m_index), 64'(k));
        check($sformatf("t%0d_re%0d", tag, k), 64'(m_real), 64'(exp_re(tag, k)));
        check($sformatf("t%0d_im%0d", tag, k), 64'(m_imag), 64'(exp_im(tag, k)));
        check($sformatf("t%0d_last%0d", tag, k), 64'(m_last), 64'(k == 63));
        k++;
      end else begin
        if (contig == 2 || (contig == 1 && k > 0))
          check($sformatf("t%0d_gap_before%0d", tag, k), 64'(m_valid), 64'd1);
        if (m_valid) begin
          held = 1'b1;
          snap = {m_valid, m_last, m_index, m_real, m_imag};
        end
      end
      step();
      if (held)
        check($sformatf("t%0d_stable%0d", tag, k), 64'({m_valid, m_last, m_index, m_real, m_imag}), 64'(snap));
      guard++;
    end
    done_in = 1'b0;
    if (k < nbeats) check($sformatf("t%0d_timeout", tag), 64'(k), 64'(nbeats));
  endtask

  initial begin
    rst      = 1'b1;
    done_in  = 1'b0;
    m_ready  = 1'b0;
    din_real = '0;
    din_imag = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_index", 64'(m_index), 64'd0);
    check("rst_real", 64'(m_real), 64'd0);
    check("rst_imag", 64'(m_imag), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Single ramp frame with latency check.
    m_ready = 1'b1;
    pulse(0);
    check("lat_t_valid", 64'(m_valid), 64'd0);
    check("lat_t_busy", 64'(busy), 64'd1);
    step();
    check("lat_t1_valid", 64'(m_valid), 64'd1);
    check("lat_t1_index", 64'(m_index), 64'd0);
    recv_frame(0, 64, 1'b0, 2, -1, 0);
    check("ramp_busy_after", 64'(busy), 64'd0);
    check("ramp_valid_after", 64'(m_valid), 64'd0);

    // Backpressure.
    pulse(1);
    recv_frame(1, 64, 1'b1, 0, -1, 0);
    check("bp_busy_after", 64'(busy), 64'd0);

    // Back-to-back frames captured 10 cycles apart.
    pulse(2);
    recv_frame(2, 64, 1'b0, 1, 9, 3);
    recv_frame(3, 64, 1'b0, 2, -1, 0);
    check("b2b_busy_after", 64'(busy), 64'd0);

    // Overflow: third frame with both buffers full is dropped.
    m_ready = 1'b0;
    pulse(4);
    pulse(5);
    pulse(6);
    step();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    check("ovf_hold_idx", 64'(m_index), 64'd0);
    recv_frame(4, 64, 1'b0, 1, -1, 0);
    recv_frame(5, 64, 1'b0, 2, -1, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ovf_no_third%0d", i), 64'(m_valid), 64'd0);
      step();
    end
    check("ovf_busy_after", 64'(busy), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Simultaneous release: new frame on the final handshake of the current one.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_ovf", 64'(overflow), 64'd0);
    check("rst2_drop", 64'(drop_cnt), 64'd0);
    m_ready = 1'b0;
    pulse(7);
    pulse(8);
    step();
    check("rel_busy", 64'(busy), 64'd1);
    recv_frame(7, 64, 1'b0, 1, 63, 9);
    recv_frame(8, 64, 1'b0, 2, -1, 0);
    recv_frame(9, 64, 1'b0, 2, -1, 0);
    check("rel_ovf", 64'(overflow), 64'd0);
    check("rel_drop", 64'(drop_cnt), 64'd0);
    check("rel_busy_after", 64'(busy), 64'd0);

    // Reset mid-stream at index 20, with a done_in that must be ignored.
    pulse(10);
    recv_frame(10, 20, 1'b0, 1, -1, 0);
    check("mid_idx20", 64'(m_index), 64'd20);
    fill(11);
    rst     = 1'b1;
    done_in = 1'b1;
    step();
    rst     = 1'b0;
    done_in = 1'b0;
    check("mid_valid", 64'(m_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_drop", 64'(drop_cnt), 64'd0);
    step();
    step();
    check("mid_valid_later", 64'(m_valid), 64'd0);
    check("mid_busy_later", 64'(busy), 64'd0);
    pulse(12);
    recv_frame(12, 64, 1'b0, 1, -1, 0);
    check("mid_busy_after", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
